i2s_rx_array: RTL and testbench

Multi-lane I2S receiver and WS generator. It is the parametrised successor of the single-lane I2S-to-PCM front end. `clk` is the serial bit clock shared by all microphones. The block drives WS and deserialises NUM_LANES stereo data lanes in parallel. It hands complete stereo frames (all lanes, left and right) to the channel buffers through a valid/ready handshake with overrun detection.

---
 rtl/i2s_rx_array.sv | 97 +++++++++
 tb/tb_i2s_rx_array.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_array.sv
// Multi-lane I2S receiver: drives WS from a slot counter and deserialises NUM_LANES stereo lanes.
// Completed stereo frames are handed off through valid/ready with sticky overrun on drops.
module i2s_rx_array #(
    parameter int unsigned NUM_LANES   = 8,
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned SLOT_BITS   = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [NUM_LANES-1:0]             sd_in,
    output logic                             ws_out,
    output logic [NUM_LANES*SAMPLE_BITS-1:0] left_data,
    output logic [NUM_LANES*SAMPLE_BITS-1:0] right_data,
    output logic                             frame_valid,
    input  logic                             frame_ready,
    output logic                             overrun,
    input  logic                             overrun_clr
);

    localparam int unsigned CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [CW-1:0] LastSlot = CW'(SLOT_BITS - 1);
    localparam logic [CW-1:0] LastBit  = CW'(SAMPLE_BITS);

    logic [CW-1:0]                             slot_cnt;
    logic [NUM_LANES-1:0][SAMPLE_BITS-1:0]     left_shift;
    logic [NUM_LANES-1:0][SAMPLE_BITS-1:0]     right_shift;
    logic [NUM_LANES-1:0][SAMPLE_BITS-1:0]     left_next;
    logic [NUM_LANES-1:0][SAMPLE_BITS-1:0]     right_next;
    logic                                      capture;
    logic                                      complete;
    logic                                      accept;
    logic                                      drop;

    // Slot 0 is the I2S one-bit delay; slots past SAMPLE_BITS are padding.
    always_comb begin
        capture    = enable && (slot_cnt != '0) && (slot_cnt <= LastBit);
        complete   = enable && ws_out && (slot_cnt == LastBit);
        accept     = complete && (!frame_valid || frame_ready);
        drop       = complete && frame_valid && !frame_ready;
        left_next  = left_shift;
        right_next = right_shift;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (capture && !ws_out) begin
                left_next[i] = {left_shift[i][SAMPLE_BITS-2:0], sd_in[i]};
            end
            if (capture && ws_out) begin
                right_next[i] = {right_shift[i][SAMPLE_BITS-2:0], sd_in[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            ws_out      <= 1'b0;
            left_shift  <= '0;
            right_shift <= '0;
            left_data   <= '0;
            right_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (!enable) begin
                slot_cnt    <= '0;
                ws_out      <= 1'b0;
                left_shift  <= '0;
                right_shift <= '0;
            end else begin
                if (slot_cnt == LastSlot) begin
                    slot_cnt <= '0;
                    ws_out   <= ~ws_out;
                end else begin
                    slot_cnt <= slot_cnt + CW'(1);
                end
                left_shift  <= left_next;
                right_shift <= right_next;
            end

            // The candidate includes the right-channel bit sampled on the completion edge.
            if (accept) begin
                left_data   <= left_next;
                right_data  <= right_next;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_array.sv
// Self-checking bench for i2s_rx_array: serial stimulus generated from chosen frame words,
// compared every cycle against a frame-level handshake model.
module tb_i2s_rx_array;

    localparam int NL  = 2;
    localparam int SB  = 8;
    localparam int SLB = 16;
    localparam int FP  = 2 * SLB;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [NL-1:0]     sd_in = '0;
    logic              ws_out;
    logic [NL*SB-1:0]  left_data;
    logic [NL*SB-1:0]  right_data;
    logic              frame_valid;
    logic              frame_ready = 1'b1;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    i2s_rx_array #(
        .NUM_LANES  (NL),
        .SAMPLE_BITS(SB),
        .SLOT_BITS  (SLB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sd_in      (sd_in),
        .ws_out     (ws_out),
        .left_data  (left_data),
        .right_data (right_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // t = position within the enabled stream of the next clock edge (0 = first enabled edge).
    int         t = 0;
    bit         fixed_mode = 1'b1;
    logic [SB-1:0] tx_l [NL];
    logic [SB-1:0] tx_r [NL];
    logic [NL*SB-1:0] m_left  = '0;
    logic [NL*SB-1:0] m_right = '0;
    bit m_valid = 1'b0;
    bit m_ovr   = 1'b0;
    bit m_ws    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_sd();
        int k;
        bit ws;
        k  = t % SLB;
        ws = ((t / SLB) % 2) == 1;
        if (enable && (t % FP) == 0) begin
            if (fixed_mode) begin
                tx_l[0] = 8'hA5; tx_r[0] = 8'h3C;
                tx_l[1] = 8'h81; tx_r[1] = 8'h7E;
            end else begin
                for (int i = 0; i < NL; i++) begin
                    tx_l[i] = SB'($urandom);
                    tx_r[i] = SB'($urandom);
                end
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (enable && k >= 1 && k <= SB) begin
                sd_in[i] = ws ? tx_r[i][SB-k] : tx_l[i][SB-k];
            end else begin
                sd_in[i] = fixed_mode ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic model_edge();
        bit complete;
        bit drop;
        logic [NL*SB-1:0] cand_l;
        logic [NL*SB-1:0] cand_r;
        complete = 1'b0;
        drop     = 1'b0;
        if (enable) begin
            complete = (t % FP) == (SLB + SB);
            t        = t + 1;
            m_ws     = ((t / SLB) % 2) == 1;
        end else begin
            t    = 0;
            m_ws = 1'b0;
        end
        for (int i = 0; i < NL; i++) begin
            cand_l[i*SB +: SB] = tx_l[i];
            cand_r[i*SB +: SB] = tx_r[i];
        end
        if (complete) begin
            if (!m_valid || frame_ready) begin
                m_left  = cand_l;
                m_right = cand_r;
                m_valid = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (m_valid && frame_ready) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (overrun_clr) m_ovr = 1'b0;
    endtask

    task automatic compare();
        check("ws_out", 32'(ws_out), 32'(m_ws));
        check("left_data", 32'(left_data), 32'(m_left));
        check("right_data", 32'(right_data), 32'(m_right));
        check("frame_valid", 32'(frame_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic step();
        drive_sd();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run_to(input int phase);
        int n;
        n = 0;
        while ((t % FP) != phase && n < 100) begin
            step();
            n++;
        end
        if ((t % FP) != phase) begin
            checks++;
            errors++;
            $display("FAIL run_to: phase %0d got %0d", phase, t % FP);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ws"}, 32'(ws_out), 32'd0);
        check({tag, "_left"}, 32'(left_data), 32'd0);
        check({tag, "_right"}, 32'(right_data), 32'd0);
        check({tag, "_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NL; i++) begin
            tx_l[i] = '0;
            tx_r[i] = '0;
        end
        // Reset state and WS timing
        #12;
        check_all_zero("reset");
        reset  = 1'b0;
        enable = 1'b1;
        repeat (15) step();
        check("ws_edge14", 32'(ws_out), 32'd0);
        step();
        check("ws_edge15", 32'(ws_out), 32'd1);
        repeat (8) step();
        check("valid_before_24", 32'(frame_valid), 32'd0);
        step();
        check("left_lit", 32'(left_data), 32'h81A5);
        check("right_lit", 32'(right_data), 32'h7E3C);
        check("valid_edge24", 32'(frame_valid), 32'd1);
        step();
        check("valid_one_cycle", 32'(frame_valid), 32'd0);
        repeat (6) step();
        check("ws_edge31", 32'(ws_out), 32'd0);
        repeat (FP * 2) step();

        // Back-pressure across two completions
        frame_ready = 1'b0;
        run_to(25);
        check("bp_valid", 32'(frame_valid), 32'd1);
        fixed_mode = 1'b0;
        repeat (FP) step();
        check("bp_ovr", 32'(overrun), 32'd1);
        check("bp_held_left", 32'(left_data), 32'h81A5);
        check("bp_held_right", 32'(right_data), 32'h7E3C);
        frame_ready = 1'b1;
        step();
        check("bp_drain", 32'(frame_valid), 32'd0);
        check("bp_ovr_sticky", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // Ready rising exactly on a completion edge
        frame_ready = 1'b0;
        run_to(25);
        run_to(24);
        frame_ready = 1'b1;
        step();
        check("refill_valid", 32'(frame_valid), 32'd1);
        check("refill_ovr", 32'(overrun), 32'd0);

        // Enable dropped mid left slot
        run_to(5);
        enable = 1'b0;
        repeat (3) step();
        check("dis_ws", 32'(ws_out), 32'd0);
        check("dis_valid", 32'(frame_valid), 32'd0);
        enable = 1'b1;
        repeat (24) step();
        check("resume_valid_24", 32'(frame_valid), 32'd0);
        step();
        check("resume_valid_25", 32'(frame_valid), 32'd1);

        // Async reset with a held frame in the right slot
        frame_ready = 1'b0;
        run_to(27);
        check("held_before_rst", 32'(frame_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        t       = 0;
        m_left  = '0;
        m_right = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ws    = 1'b0;
        #2;
        reset = 1'b0;

        // Randomized run
        for (int n = 0; n < 1500; n++) begin
            frame_ready = $urandom_range(0, 3) != 0;
            overrun_clr = $urandom_range(0, 15) == 0;
            enable      = $urandom_range(0, 199) != 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
